lieat_exu_vpu_vcfg: RTL

Parametrised vector-configuration execution unit for the VPU EXU; handles vsetvli, vsetivli and vsetvl.
- Two-stage pipeline: S1 capture/decode, S2 result.
- Owns the architectural vl and vtype registers.
- Forwards uncommitted S2 results to a dependent S1 instruction.
- Returns the new vl to the integer writeback path.

---
 rtl/lieat_exu_vpu_vcfg_pkg.sv | 42 ++++
 rtl/lieat_exu_vpu_vlmax.sv | 25 ++
 rtl/lieat_general_dfflr.sv | 15 +
 rtl/lieat_exu_vpu_vcfg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lieat_exu_vpu_vcfg_pkg.sv
// lieat_exu_vpu_vcfg_pkg: shared vector-configuration encodings, vtype layout and helpers.
package lieat_exu_vpu_vcfg_pkg;

  typedef enum logic [1:0] {
    VCFG_OP_VSETVLI  = 2'b00,
    VCFG_OP_VSETIVLI = 2'b01,
    VCFG_OP_VSETVL   = 2'b10,
    VCFG_OP_RSVD     = 2'b11
  } vcfg_op_e;

  localparam int VTYPE_VMA       = 7;
  localparam int VTYPE_VTA       = 6;
  localparam int VTYPE_VSEW_LSB  = 3;
  localparam int VTYPE_VLMUL_LSB = 0;

  localparam logic [2:0] VSEW_8  = 3'b000;
  localparam logic [2:0] VSEW_16 = 3'b001;
  localparam logic [2:0] VSEW_32 = 3'b010;
  localparam logic [2:0] VSEW_64 = 3'b011;

  localparam logic [2:0] VLMUL_1    = 3'b000;
  localparam logic [2:0] VLMUL_2    = 3'b001;
  localparam logic [2:0] VLMUL_4    = 3'b010;
  localparam logic [2:0] VLMUL_8    = 3'b011;
  localparam logic [2:0] VLMUL_RSVD = 3'b100;
  localparam logic [2:0] VLMUL_F8   = 3'b101;
  localparam logic [2:0] VLMUL_F4   = 3'b110;
  localparam logic [2:0] VLMUL_F2   = 3'b111;

  typedef struct packed {
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  // log2(SEW/LMUL) up to a constant offset; vlmul read as a signed log2(LMUL)
  function automatic logic signed [4:0] vtype_ratio(vtype_t vt);
    return $signed({2'b00, vt.vsew}) - $signed({{2{vt.vlmul[2]}}, vt.vlmul});
  endfunction

endpackage

// File: rtl/lieat_exu_vpu_vlmax.sv
// lieat_exu_vpu_vlmax: combinational (vsew, vlmul) -> vlmax and legality; vlmax is 0 when illegal.
module lieat_exu_vpu_vlmax
  import lieat_exu_vpu_vcfg_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic [2:0]     vsew,
  input  logic [2:0]     vlmul,
  output logic [VLW-1:0] vlmax,
  output logic           legal
);
  localparam int ELEN_LOG = $clog2(ELEN);
  logic [VLW-1:0] base;
  logic [3:0]     frac_log;
  always_comb begin
    base     = VLW'(VLEN >> 3) >> vsew;
    frac_log = 4'd8 - {1'b0, vlmul};
    // fractional LMUL needs SEW <= ELEN*LMUL, i.e. log2(SEW) + log2(1/LMUL) <= log2(ELEN)
    legal    = (vlmul != VLMUL_RSVD) && ({1'b0, vsew} <= 4'(ELEN_LOG - 3))
            && (!vlmul[2] || (5'd3 + {2'b00, vsew} + {1'b0, frac_log} <= 5'(ELEN_LOG)));
    vlmax    = !legal ? '0 : vlmul[2] ? base >> frac_log : base << vlmul[1:0];
  end
endmodule

// File: rtl/lieat_general_dfflr.sv
// lieat_general_dfflr: load-enabled register with asynchronous active-low reset to RST.
module lieat_general_dfflr #(
  parameter int            DW  = 1,
  parameter logic [DW-1:0] RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) qout <= RST;
    else if (lden) qout <= dnxt;
endmodule

// File: rtl/lieat_exu_vpu_vcfg.sv
// lieat_exu_vpu_vcfg: two-stage vsetvli/vsetivli/vsetvl unit owning the vl and vtype CSRs.
// Define VPU_VCFG_VILL_CHECK_EN to set vill on illegal configs and on x0/x0 SEW/LMUL ratio changes.
module lieat_exu_vpu_vcfg
  import lieat_exu_vpu_vcfg_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int VLEN = 128,
  parameter  int ELEN = 32,
  localparam int VLW  = $clog2(VLEN) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_req,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [1:0]      i_op,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic [4:0]      i_uimm,
  input  logic [10:0]     i_zimm,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic            o_wen,
  output logic [VLW-1:0]  csr_vl,
  output logic [XLEN-1:0] csr_vtype,
  output logic            csr_vstart_clr
);
  localparam logic [XLEN-1:0] VILL = {1'b1, {(XLEN-1){1'b0}}};
`ifdef VPU_VCFG_VILL_CHECK_EN
  localparam logic [XLEN-1:0] VTYPE_RST = VILL;
`else
  localparam logic [XLEN-1:0] VTYPE_RST = '0;
`endif

  logic            o_sh, s2_adv, s1_ld, s2_ld, commit, is_ivli, is_vl;
  logic            s1_valid_d, s1_valid_q, s1_keep_d, s1_keep_q, s1_hi_d, s1_hi_q;
  logic [XLEN-1:0] s1_avl_d, s1_avl_q, s1_pc_q;
  vtype_t          s1_vt_d, s1_vt_q;
  logic [4:0]      s1_rd_q;
  logic            s2_valid_d, s2_valid_q;
  logic [VLW-1:0]  s2_vl_d, s2_vl_q;
  logic [XLEN-1:0] s2_vtype_d, s2_vtype_q, s2_pc_q;
  logic [4:0]      s2_rd_q;
  logic [VLW-1:0]  csr_vl_d, csr_vl_q;
  logic [XLEN-1:0] csr_vtype_d, csr_vtype_q;
  logic            csr_vstart_clr_d, csr_vstart_clr_q;
  logic [VLW-1:0]  vlmax, cur_vl;
  logic            legal;
  logic [XLEN-1:0] avl, vlmax_x, vl_min;
`ifdef VPU_VCFG_VILL_CHECK_EN
  vtype_t          cur_vt;
  logic            vill;
`endif
  logic            unused_bits;

  assign o_sh    = s2_valid_q & o_ready;
  assign s2_adv  = ~s2_valid_q | o_sh;
  assign i_ready = ~s1_valid_q | s2_adv;
  assign s1_ld   = i_valid & i_ready;
  assign s2_ld   = s2_adv & s1_valid_q;
  assign commit  = o_sh & ~flush_req;

  // capture: resolve AVL source and vtype source at accept time
  always_comb begin
    is_ivli   = i_op == VCFG_OP_VSETIVLI;
    is_vl     = i_op == VCFG_OP_VSETVL;
    s1_keep_d = ~is_ivli & (i_rs1 == '0) & (i_rd == '0);
    s1_avl_d  = is_ivli ? {{(XLEN-5){1'b0}}, i_uimm} : (i_rs1 != '0) ? i_src1 : (i_rd != '0) ? '1 : '0;
    s1_vt_d   = is_vl ? vtype_t'(i_src2[7:0]) : vtype_t'(i_zimm[7:0]);
    s1_hi_d   = is_vl & (|i_src2[XLEN-2:8]);
  end

  lieat_exu_vpu_vlmax #(.VLEN(VLEN), .ELEN(ELEN), .VLW(VLW)) u_vlmax (
    .vsew (s1_vt_q.vsew),
    .vlmul(s1_vt_q.vlmul),
    .vlmax(vlmax),
    .legal(legal)
  );

  // S1 result; x0/x0 reads the uncommitted S2 vl ahead of the CSR
  always_comb begin
    cur_vl  = s2_valid_q ? s2_vl_q : csr_vl_q;
    avl     = s1_keep_q ? {{(XLEN-VLW){1'b0}}, cur_vl} : s1_avl_q;
    vlmax_x = {{(XLEN-VLW){1'b0}}, vlmax};
    vl_min  = (avl < vlmax_x) ? avl : vlmax_x;
`ifdef VPU_VCFG_VILL_CHECK_EN
    cur_vt     = vtype_t'(s2_valid_q ? s2_vtype_q[7:0] : csr_vtype_q[7:0]);
    vill       = ~legal | s1_hi_q | (s1_keep_q & (vtype_ratio(s1_vt_q) != vtype_ratio(cur_vt)));
    s2_vl_d    = vill ? '0 : VLW'(vl_min);
    s2_vtype_d = vill ? VILL : {{(XLEN-8){1'b0}}, s1_vt_q};
`else
    s2_vl_d    = VLW'(vl_min);
    s2_vtype_d = {{(XLEN-8){1'b0}}, s1_vt_q};
`endif
  end

  always_comb begin
    s1_valid_d       = ~flush_req & (i_ready ? i_valid : s1_valid_q);
    s2_valid_d       = ~flush_req & (s2_adv ? s1_valid_q : s2_valid_q);
    csr_vl_d         = commit ? s2_vl_q : csr_vl_q;
    csr_vtype_d      = commit ? s2_vtype_q : csr_vtype_q;
    csr_vstart_clr_d = commit;
  end

  lieat_general_dfflr #(.DW(1))    u_s1_valid (.clk(clock), .rst_n(reset), .lden(1'b1), .dnxt(s1_valid_d), .qout(s1_valid_q));
  lieat_general_dfflr #(.DW(1))    u_s1_keep  (.clk(clock), .rst_n(reset), .lden(s1_ld), .dnxt(s1_keep_d),  .qout(s1_keep_q));
  lieat_general_dfflr #(.DW(1))    u_s1_hi    (.clk(clock), .rst_n(reset), .lden(s1_ld), .dnxt(s1_hi_d),    .qout(s1_hi_q));
  lieat_general_dfflr #(.DW(XLEN)) u_s1_avl   (.clk(clock), .rst_n(reset), .lden(s1_ld), .dnxt(s1_avl_d),   .qout(s1_avl_q));
  lieat_general_dfflr #(.DW(8))    u_s1_vt    (.clk(clock), .rst_n(reset), .lden(s1_ld), .dnxt(s1_vt_d),    .qout(s1_vt_q));
  lieat_general_dfflr #(.DW(XLEN)) u_s1_pc    (.clk(clock), .rst_n(reset), .lden(s1_ld), .dnxt(i_pc),       .qout(s1_pc_q));
  lieat_general_dfflr #(.DW(5))    u_s1_rd    (.clk(clock), .rst_n(reset), .lden(s1_ld), .dnxt(i_rd),       .qout(s1_rd_q));

  lieat_general_dfflr #(.DW(1))    u_s2_valid (.clk(clock), .rst_n(reset), .lden(1'b1),  .dnxt(s2_valid_d), .qout(s2_valid_q));
  lieat_general_dfflr #(.DW(VLW))  u_s2_vl    (.clk(clock), .rst_n(reset), .lden(s2_ld), .dnxt(s2_vl_d),    .qout(s2_vl_q));
  lieat_general_dfflr #(.DW(XLEN)) u_s2_vtype (.clk(clock), .rst_n(reset), .lden(s2_ld), .dnxt(s2_vtype_d), .qout(s2_vtype_q));
  lieat_general_dfflr #(.DW(XLEN)) u_s2_pc    (.clk(clock), .rst_n(reset), .lden(s2_ld), .dnxt(s1_pc_q),    .qout(s2_pc_q));
  lieat_general_dfflr #(.DW(5))    u_s2_rd    (.clk(clock), .rst_n(reset), .lden(s2_ld), .dnxt(s1_rd_q),    .qout(s2_rd_q));

  lieat_general_dfflr #(.DW(VLW))  u_csr_vl   (.clk(clock), .rst_n(reset), .lden(1'b1), .dnxt(csr_vl_d), .qout(csr_vl_q));
  lieat_general_dfflr #(.DW(XLEN), .RST(VTYPE_RST)) u_csr_vtype (
    .clk(clock), .rst_n(reset), .lden(1'b1), .dnxt(csr_vtype_d), .qout(csr_vtype_q));
  lieat_general_dfflr #(.DW(1))    u_csr_vsc  (.clk(clock), .rst_n(reset), .lden(1'b1), .dnxt(csr_vstart_clr_d), .qout(csr_vstart_clr_q));

  assign o_valid        = s2_valid_q;
  assign o_wen          = s2_valid_q;
  assign o_data         = {{(XLEN-VLW){1'b0}}, s2_vl_q};
  assign o_pc           = s2_pc_q;
  assign o_rd           = s2_rd_q;
  assign csr_vl         = csr_vl_q;
  assign csr_vtype      = csr_vtype_q;
  assign csr_vstart_clr = csr_vstart_clr_q;
  assign unused_bits    = ^{i_zimm[10:8], i_src2[XLEN-1], s1_hi_q, legal};
endmodule
